// File: rtl/hazard_unit.sv
// Hazard unit: load-use stalls, redirect flushes and EX-stage forward selects
// for the ID/EX stage, plus saturating stall/flush event counters.
module hazard_unit #(
  parameter int CNT_W     = 16,
  parameter int XLEN_REGS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN_REGS-1:0] rs1_id,
  input  logic [XLEN_REGS-1:0] rs2_id,
  input  logic                 uses_rs1_id,
  input  logic                 uses_rs2_id,
  input  logic [XLEN_REGS-1:0] rd_ex,
  input  logic                 im_to_rf_ex,
  input  logic                 load_ex,
  input  logic [XLEN_REGS-1:0] rd_mem,
  input  logic                 im_to_rf_mem,
  input  logic                 branch_taken_ex,
  input  logic                 jump_ex,
  output logic                 stall_pc,
  output logic                 stall_if_id,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [1:0]           fwd_a_ex,
  output logic [1:0]           fwd_b_ex,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    REDIRECT = 2'b10,
    UNUSED   = 2'b11
  } state_t;

  localparam logic [1:0]       FWD_RF  = 2'b00;
  localparam logic [1:0]       FWD_MEM = 2'b01;
  localparam logic [1:0]       FWD_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic depExA, depExB, depMemA, depMemB;
  logic redirect, loadUse;
  logic [1:0] nxtA, nxtB;

  state_t           state_q, state_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Register x0 is hardwired to zero, so a dependency on it is never real.
  assign depExA  = uses_rs1_id & im_to_rf_ex  & (rd_ex  == rs1_id) & (rs1_id != '0);
  assign depExB  = uses_rs2_id & im_to_rf_ex  & (rd_ex  == rs2_id) & (rs2_id != '0);
  assign depMemA = uses_rs1_id & im_to_rf_mem & (rd_mem == rs1_id) & (rs1_id != '0);
  assign depMemB = uses_rs2_id & im_to_rf_mem & (rd_mem == rs2_id) & (rs2_id != '0);

  assign redirect = branch_taken_ex | jump_ex;
  assign loadUse  = ~redirect & load_ex & (depExA | depExB);

  assign stall_pc    = loadUse;
  assign stall_if_id = loadUse;
  assign flush_if_id = redirect;
  assign flush_id_ex = redirect | loadUse;

  // Nearer producer (EX/MEM) takes precedence over the older MEM/WB value.
  assign nxtA = depExA ? FWD_MEM : (depMemA ? FWD_WB : FWD_RF);
  assign nxtB = depExB ? FWD_MEM : (depMemB ? FWD_WB : FWD_RF);

  always_comb begin
    fwd_a_d     = flush_id_ex ? FWD_RF : nxtA;
    fwd_b_d     = flush_id_ex ? FWD_RF : nxtB;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (loadUse && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    // Every state, including the unused encoding, follows the same transitions.
    if (redirect)     state_d = REDIRECT;
    else if (loadUse) state_d = LU_STALL;
    else              state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_ex  = fwd_a_q;
  assign fwd_b_ex  = fwd_b_q;
  assign state_o   = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
